ads1292_frame_reader: RTL

ADS1292_FRAME_READER -- requirements
Module: ads1292_frame_reader

---
 rtl/ads1292_frame_reader.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/ads1292_frame_reader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : ads1292_frame_reader
//  Description : Reads one 72-bit RDATAC frame (status, CH1, CH2) from an
//                ADS1292 ECG front-end after each DRDY falling edge.
//                SPI mode 1 (CPOL=0, CPHA=1), MOSI held low.
//  Revision    : 1.0 - initial release
// ============================================================================
module ads1292_frame_reader #(
  parameter int SCLK_DIV = 8
) (
  input  logic        i_CLK,
  input  logic        i_RSTN,
  input  logic        i_ENABLE,
  input  logic        ADS1292_DRDY,
  input  logic        ADS1292_MISO,
  output logic        ADS1292_SCLK,
  output logic        ADS1292_CSN,
  output logic        ADS1292_MOSI,
  output logic [23:0] o_STATUS,
  output logic [23:0] o_CH1,
  output logic [23:0] o_CH2,
  output logic        o_VALID,
  output logic        o_BUSY,
  output logic        o_OVERRUN
);

  // Frame length is fixed by the device in RDATAC mode.
  localparam int         FRAME_BITS = 72;
  localparam logic [7:0] DIV_LAST   = 8'(SCLK_DIV - 1);
  localparam logic [6:0] BIT_LAST   = 7'(FRAME_BITS - 1);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] CS_SETUP = 3'd1;
  localparam logic [2:0] SHIFT    = 3'd2;
  localparam logic [2:0] CS_HOLD  = 3'd3;
  localparam logic [2:0] DONE     = 3'd4;

  logic [2:0]            state;
  logic [2:0]            next_state;
  logic                  drdy_meta;
  logic                  drdy_sync;
  logic                  drdy_prev;
  logic                  drdy_event;
  logic [7:0]            div_cnt;
  logic                  phase_low;
  logic [6:0]            bit_cnt;
  logic [FRAME_BITS-1:0] shift_reg;
  logic                  div_last;
  logic                  sclk_d;
  logic                  csn_d;
  logic                  valid_d;
  logic                  shift_fall;

  assign div_last     = (div_cnt == DIV_LAST);
  // A bit is captured in the cycle the pad clock is driven from high to low.
  assign shift_fall   = ADS1292_SCLK & ~sclk_d;
  assign ADS1292_MOSI = 1'b0;

  // DRDY synchronizer, edge history and registered falling-edge event.
  always_ff @(posedge i_CLK or negedge i_RSTN) begin
    if (!i_RSTN) begin
      drdy_meta  <= 1'b1;
      drdy_sync  <= 1'b1;
      drdy_prev  <= 1'b1;
      drdy_event <= 1'b0;
    end else begin
      drdy_meta  <= ADS1292_DRDY;
      drdy_sync  <= drdy_meta;
      drdy_prev  <= drdy_sync;
      drdy_event <= drdy_prev & ~drdy_sync;
    end
  end

  // FSM state register.
  always_ff @(posedge i_CLK or negedge i_RSTN) begin
    if (!i_RSTN) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // FSM next-state logic; events outside IDLE never start a frame.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:     if (drdy_event && i_ENABLE) next_state = CS_SETUP;
      CS_SETUP: if (div_last) next_state = SHIFT;
      SHIFT:    if (div_last && phase_low && (bit_cnt == BIT_LAST)) next_state = CS_HOLD;
      CS_HOLD:  if (div_last) next_state = DONE;
      DONE:     next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  // FSM outputs; pad signals are registered one cycle behind the state.
  always_comb begin
    sclk_d  = (state == SHIFT) && !phase_low;
    csn_d   = (state == IDLE) || (state == DONE);
    valid_d = (state == DONE);
    o_BUSY  = (state != IDLE);
  end

  // Half-period divider, SCLK phase and bit counter; all restart on a state change.
  always_ff @(posedge i_CLK or negedge i_RSTN) begin
    if (!i_RSTN) begin
      div_cnt   <= 8'd0;
      phase_low <= 1'b0;
      bit_cnt   <= 7'd0;
    end else if (state != next_state) begin
      div_cnt   <= 8'd0;
      phase_low <= 1'b0;
      bit_cnt   <= 7'd0;
    end else if ((state == CS_SETUP) || (state == SHIFT) || (state == CS_HOLD)) begin
      if (div_last) begin
        div_cnt <= 8'd0;
        if (state == SHIFT) begin
          phase_low <= ~phase_low;
          if (phase_low) bit_cnt <= bit_cnt + 7'd1;
        end
      end else begin
        div_cnt <= div_cnt + 8'd1;
      end
    end
  end

  // Registered pad outputs and the data-valid pulse.
  always_ff @(posedge i_CLK or negedge i_RSTN) begin
    if (!i_RSTN) begin
      ADS1292_SCLK <= 1'b0;
      ADS1292_CSN  <= 1'b1;
      o_VALID      <= 1'b0;
    end else begin
      ADS1292_SCLK <= sclk_d;
      ADS1292_CSN  <= csn_d;
      o_VALID      <= valid_d;
    end
  end

  // MSB-first receive shift register; MISO is stable across the falling edge.
  always_ff @(posedge i_CLK or negedge i_RSTN) begin
    if (!i_RSTN) begin
      shift_reg <= '0;
    end else if (shift_fall) begin
      shift_reg <= {shift_reg[FRAME_BITS-2:0], ADS1292_MISO};
    end
  end

  // Output words only change on DONE, so a partial frame never appears.
  always_ff @(posedge i_CLK or negedge i_RSTN) begin
    if (!i_RSTN) begin
      o_STATUS <= 24'd0;
      o_CH1    <= 24'd0;
      o_CH2    <= 24'd0;
    end else if (valid_d) begin
      o_STATUS <= shift_reg[71:48];
      o_CH1    <= shift_reg[47:24];
      o_CH2    <= shift_reg[23:0];
    end
  end

  // Sticky overrun flag; disabling clears it and wins over a new event.
  always_ff @(posedge i_CLK or negedge i_RSTN) begin
    if (!i_RSTN) begin
      o_OVERRUN <= 1'b0;
    end else if (!i_ENABLE) begin
      o_OVERRUN <= 1'b0;
    end else if (drdy_event && (state != IDLE)) begin
      o_OVERRUN <= 1'b1;
    end
  end

endmodule
`default_nettype wire
